// File: rtl/button_conditioner.sv
// Push-button front end for the game wrapper: synchronize, debounce, edge
// pulses, long-hold flag, sticky jump request and duck decode.

// One button channel: 2-flop synchronizer plus debounce FSM with registered
// level/press/release. level_next exposes the value level takes next edge.
//   state        | meaning
//   IDLE         | level 0, s2 agrees
//   PRESS_PEND   | level 0, s2 has been 1 for cnt consecutive samples
//   HELD         | level 1, s2 agrees
//   RELEASE_PEND | level 1, s2 has been 0 for cnt consecutive samples
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic level_next,
  output logic press,
  output logic rel
);
  typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, RELEASE_PEND} state_t;

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES);

  logic             s1, s2;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_nxt, rel_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_next;
      press <= press_nxt;
      rel   <= rel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (s2) begin
        state_nxt = PRESS_PEND;
        cnt_nxt   = CNT_W'(1);
      end
      PRESS_PEND: begin
        if (!s2) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_TC) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: if (!s2) begin
        state_nxt = RELEASE_PEND;
        cnt_nxt   = CNT_W'(1);
      end
      RELEASE_PEND: begin
        if (s2) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DEB_TC) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    level_next = (state_nxt == HELD) || (state_nxt == RELEASE_PEND);
    press_nxt  = (state == PRESS_PEND) && (state_nxt == HELD);
    rel_nxt    = (state == RELEASE_PEND) && (state_nxt == IDLE);
  end
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 20000000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic jump_ack,
  output logic up_level,
  output logic down_level,
  output logic up_press,
  output logic up_release,
  output logic down_press,
  output logic up_long,
  output logic jump_req,
  output logic duck
);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES);

  logic             up_level_nxt, down_level_nxt, down_rel_unused;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_up (
    .clk(clk), .reset(reset), .raw(btn_up),
    .level(up_level), .level_next(up_level_nxt),
    .press(up_press), .rel(up_release)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_down (
    .clk(clk), .reset(reset), .raw(btn_down),
    .level(down_level), .level_next(down_level_nxt),
    .press(down_press), .rel(down_rel_unused)
  );

  // Count only while the level is already high, so the press cycle reads 0
  // and up_long lands exactly HOLD_CYCLES after up_press.
  always_comb begin
    hold_nxt = hold_cnt;
    if (!up_level_nxt)
      hold_nxt = '0;
    else if (up_level && hold_cnt != HOLD_TC)
      hold_nxt = hold_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      up_long  <= 1'b0;
      jump_req <= 1'b0;
      duck     <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      up_long  <= up_level_nxt && (hold_nxt == HOLD_TC);
      // A fresh press outranks a simultaneous ack so no tap is lost.
      if (up_press)
        jump_req <= 1'b1;
      else if (jump_ack)
        jump_req <= 1'b0;
      duck <= down_level_nxt & ~up_level_nxt;
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed test-plan sequence with literal
// expectations, then random button/ack/reset traffic against a run-length model.
module tb_button_conditioner;
  localparam int D = 4;
  localparam int H = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, jump_ack = 1'b0;
  logic up_level, down_level, up_press, up_release, down_press, up_long, jump_req, duck;

  int checks = 0;
  int failures = 0;
  int dp_count = 0;
  bit count_dp = 1'b0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .jump_ack(jump_ack),
    .up_level(up_level), .down_level(down_level), .up_press(up_press),
    .up_release(up_release), .down_press(down_press), .up_long(up_long),
    .jump_req(jump_req), .duck(duck)
  );

  // Model: a level flips once its synchronized input has disagreed with it on
  // D+1 consecutive clock samples. Index 0 = up, 1 = down.
  typedef struct {
    bit [1:0] s1, s2, lvl, press, rel;
    int       run_up, run_dn, hc;
    bit       lng, jreq, duck;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t zero_state();
    mstate_t z;
    z.s1 = '0; z.s2 = '0; z.lvl = '0; z.press = '0; z.rel = '0;
    z.run_up = 0; z.run_dn = 0; z.hc = 0;
    z.lng = 1'b0; z.jreq = 1'b0; z.duck = 1'b0;
    return z;
  endfunction

  function automatic mstate_t step(input mstate_t c, input bit [1:0] raw, input bit ack);
    mstate_t n;
    int run [2];
    n = c;
    run[0] = c.run_up;
    run[1] = c.run_dn;
    n.jreq = c.press[0] ? 1'b1 : (ack ? 1'b0 : c.jreq);
    n.press = '0;
    n.rel = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (c.s2[ch] != c.lvl[ch]) begin
        run[ch] = run[ch] + 1;
        if (run[ch] == D + 1) begin
          n.lvl[ch]   = c.s2[ch];
          n.press[ch] = c.s2[ch];
          n.rel[ch]   = ~c.s2[ch];
          run[ch]     = 0;
        end
      end else begin
        run[ch] = 0;
      end
    end
    n.run_up = run[0];
    n.run_dn = run[1];
    // hc = cycles elapsed since up_press, saturating at H
    if (!n.lvl[0]) n.hc = 0;
    else if (c.lvl[0] && c.hc < H) n.hc = c.hc + 1;
    n.lng  = n.lvl[0] && (n.hc == H);
    n.duck = n.lvl[1] & ~n.lvl[0];
    n.s2 = c.s1;
    n.s1 = raw;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= zero_state();
    else        m <= step(m, {btn_down, btn_up}, jump_ack);
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_up_level", up_level, m.lvl[0]);
    chk("model_down_level", down_level, m.lvl[1]);
    chk("model_up_press", up_press, m.press[0]);
    chk("model_up_release", up_release, m.rel[0]);
    chk("model_down_press", down_press, m.press[1]);
    chk("model_up_long", up_long, m.lng);
    chk("model_jump_req", jump_req, m.jreq);
    chk("model_duck", duck, m.duck);
    if (count_dp && down_press === 1'b1) dp_count++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    jump_ack = 1'b1;
    cyc(1);
    jump_ack = 1'b0;
  endtask

  initial begin
    bit [4:0] bounce;
    // 1: button held through reset must re-qualify from the first sample
    btn_up = 1'b1;
    cyc(3);
    chk("rst_up_level", up_level, 1'b0);
    chk("rst_up_press", up_press, 1'b0);
    chk("rst_jump_req", jump_req, 1'b0);
    chk("rst_duck", duck, 1'b0);
    reset = 1'b1;
    cyc(6);
    chk("t1_up_level_early", up_level, 1'b0);
    cyc(1);
    chk("t1_up_level_rise", up_level, 1'b1);
    chk("t1_up_press", up_press, 1'b1);
    cyc(1);
    chk("t1_up_press_single", up_press, 1'b0);
    chk("t1_jump_req_set", jump_req, 1'b1);
    btn_up = 1'b0;
    cyc(6);
    chk("t1_up_level_hold", up_level, 1'b1);
    cyc(1);
    chk("t1_up_level_fall", up_level, 1'b0);
    chk("t1_up_release", up_release, 1'b1);
    ack_pulse();
    chk("t1_ack_clears", jump_req, 1'b0);
    cyc(4);

    // 2: bounce 1,0,1,1,0 must be rejected
    bounce = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      btn_up = bounce[i];
      cyc(1);
    end
    btn_up = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      chk("t2_no_level", up_level, 1'b0);
      chk("t2_no_req", jump_req, 1'b0);
    end

    // 3: clean press, long hold, release
    btn_up = 1'b1;
    cyc(7);
    chk("t3_level", up_level, 1'b1);
    chk("t3_press", up_press, 1'b1);
    cyc(9);
    chk("t3_long_early", up_long, 1'b0);
    cyc(1);
    chk("t3_long_set", up_long, 1'b1);
    cyc(3);
    btn_up = 1'b0;
    cyc(6);
    chk("t3_long_hold", up_long, 1'b1);
    cyc(1);
    chk("t3_level_fall", up_level, 1'b0);
    chk("t3_long_drop", up_long, 1'b0);
    chk("t3_release", up_release, 1'b1);

    // 4: sticky request and ack handshake
    cyc(50);
    chk("t4_req_sticky", jump_req, 1'b1);
    ack_pulse();
    chk("t4_req_cleared", jump_req, 1'b0);
    ack_pulse();
    chk("t4_second_ack", jump_req, 1'b0);

    // 5: ack in the exact cycle of a second press keeps the request
    btn_up = 1'b1;
    cyc(10);
    btn_up = 1'b0;
    cyc(8);
    chk("t5_req_pending", jump_req, 1'b1);
    btn_up = 1'b1;
    cyc(7);
    chk("t5_second_press", up_press, 1'b1);
    ack_pulse();
    chk("t5_press_wins", jump_req, 1'b1);
    cyc(1);
    chk("t5_press_wins_hold", jump_req, 1'b1);
    btn_up = 1'b0;
    cyc(8);
    ack_pulse();

    // 6: up has priority over down for duck
    count_dp = 1'b1;
    btn_down = 1'b1;
    cyc(7);
    chk("t6_down_level", down_level, 1'b1);
    chk("t6_duck_on", duck, 1'b1);
    cyc(2);
    btn_up = 1'b1;
    cyc(7);
    chk("t6_up_level", up_level, 1'b1);
    chk("t6_duck_off", duck, 1'b0);
    cyc(3);
    btn_up = 1'b0;
    cyc(7);
    chk("t6_up_dropped", up_level, 1'b0);
    chk("t6_duck_back", duck, 1'b1);
    count_dp = 1'b0;
    checks++;
    if (dp_count != 1) begin
      failures++;
      $display("FAIL t6_down_press_count actual=%0d expected=1", dp_count);
    end
    btn_down = 1'b0;
    cyc(8);

    // random traffic against the model
    for (int seg = 0; seg < 160; seg++) begin
      int len;
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b0;
        cyc($urandom_range(1, 3));
        reset = 1'b1;
      end
      btn_up   = $urandom_range(0, 1) == 1;
      btn_down = $urandom_range(0, 1) == 1;
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 22);
      for (int k = 0; k < len; k++) begin
        jump_ack = ($urandom_range(0, 7) == 0);
        cyc(1);
      end
    end
    jump_ack = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
